// File: rtl/brg_cgra_mem_arbiter_pkg.sv
// Shared definitions for the CGRA memory arbiter: FSM states, packet opcode
// and return-type encodings, requester-to-reg_id mapping and width helpers.
// Optional build macro used by the top: BRG_CGRA_ARB_PERF_EN.
package brg_cgra_pkg;

    // Drain handshake FSM states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } arb_state_e;

    // Outgoing packet opcodes
    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1
    } pkt_op_e;

    // reg_id field width; the requester index rides in it unchanged
    localparam int REG_ID_W = 5;

    // Returned packet type for a write acknowledgement; anything else is load data
    localparam logic [1:0] RET_PKT_CREDIT = 2'd0;

    // Byte mask carried in op_ex for full-word stores
    localparam logic [3:0] STORE_MASK = 4'hF;
    localparam int OP_EX_W = 4;
    localparam int OP_W    = 2;

    // Requester index -> reg_id tag
    function automatic logic [REG_ID_W-1:0] reg_id_of(input int idx);
        return REG_ID_W'(idx);
    endfunction

    // Bits needed to hold an outstanding count of 0..max_cnt
    function automatic int cnt_width(input int max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

    // Packet layout, MSB to LSB:
    // {addr, op, op_ex, reg_id, payload, src_y, src_x, dst_y, dst_x}
    function automatic int packet_width(input int addr_w, input int data_w,
                                        input int x_w, input int y_w);
        return addr_w + OP_W + OP_EX_W + REG_ID_W + data_w + 2 * (x_w + y_w);
    endfunction

endpackage

// File: rtl/brg_cgra_mem_arbiter_if.sv
// Requester-side bus between the CGRA memory engines and the arbiter.
// Signal names are seen from the arbiter (slave) side.
interface brg_cgra_mem_arbiter_if #(
    parameter int num_req_p    = 4,
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32
);
    logic [num_req_p-1:0]              req_v_i;
    logic [num_req_p-1:0]              req_we_i;
    logic [num_req_p*addr_width_p-1:0] req_addr_i;
    logic [num_req_p*data_width_p-1:0] req_data_i;
    logic [num_req_p-1:0]              req_ready_o;
    logic [num_req_p-1:0]              resp_v_o;
    logic [data_width_p-1:0]           resp_data_o;
    logic [num_req_p-1:0]              resp_ready_i;

    // Memory engines drive requests and accept responses
    modport master (
        output req_v_i, req_we_i, req_addr_i, req_data_i, resp_ready_i,
        input  req_ready_o, resp_v_o, resp_data_o
    );

    // Arbiter accepts requests and drives responses
    modport slave (
        input  req_v_i, req_we_i, req_addr_i, req_data_i, resp_ready_i,
        output req_ready_o, resp_v_o, resp_data_o
    );
endinterface

// File: rtl/brg_cgra_mem_arbiter_rr.sv
// Round-robin arbiter: picks the first eligible requester at or after the
// pointer, wrapping around; the pointer moves past the winner on yumi.
module brg_cgra_rr_arbiter #(
    parameter int num_req_p = 4,
    localparam int idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [num_req_p-1:0] eligible_i,
    input  logic                 yumi_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [idx_w_lp-1:0]  grant_idx_o
);

    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_req_p - 1);

    logic [idx_w_lp-1:0] rr_ptr_q;
    logic [idx_w_lp-1:0] rr_ptr_d;
    logic                found;

    // Two passes: first requesters at/after the pointer, then the wrap-around
    always_comb begin
        grant_idx_o = '0;
        found       = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            if (!found && eligible_i[k] && (k >= int'(rr_ptr_q))) begin
                grant_idx_o = idx_w_lp'(k);
                found       = 1'b1;
            end
        end
        for (int k = 0; k < num_req_p; k++) begin
            if (!found && eligible_i[k]) begin
                grant_idx_o = idx_w_lp'(k);
                found       = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_grant
        assign grant_o[gi] = found & (grant_idx_o == idx_w_lp'(gi));
    end

    // Next pointer is one past the winner, modulo the requester count
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (yumi_i) begin
            rr_ptr_d = (grant_idx_o == last_idx_lp) ? '0 : grant_idx_o + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/brg_cgra_mem_arbiter.sv
// Shares one endpoint master port among the CGRA memory engines: round-robin
// issue gated by credits and a per-requester outstanding limit, reg_id tagging,
// return routing and a drain handshake for reconfiguration.
// Optional: define BRG_CGRA_ARB_PERF_EN for per-requester stall counters and a
// total-issue counter on perf_stall_o / perf_issue_o.
module brg_cgra_mem_arbiter
    import brg_cgra_pkg::*;
#(
    parameter int num_req_p         = 4,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int max_out_credits_p = 200,
    parameter int max_outstanding_p = 4,
    localparam int packet_width_lp  = packet_width(addr_width_p, data_width_p,
                                                   x_cord_width_p, y_cord_width_p),
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i,
    input  logic [x_cord_width_p-1:0]  tgt_x_i,
    input  logic [y_cord_width_p-1:0]  tgt_y_i,
    brg_cgra_mem_arbiter_if.slave      req_if,
    output logic                       out_v_o,
    output logic [packet_width_lp-1:0] out_packet_o,
    input  logic                       out_ready_i,
    input  logic [credit_width_lp-1:0] out_credits_i,
    input  logic                       returned_v_r_i,
    input  logic [data_width_p-1:0]    returned_data_r_i,
    input  logic [REG_ID_W-1:0]        returned_reg_id_r_i,
    input  logic [1:0]                 returned_pkt_type_r_i,
    output logic                       returned_yumi_o,
    input  logic                       drain_i,
    output logic                       drained_o
`ifdef BRG_CGRA_ARB_PERF_EN
    ,
    output logic [num_req_p*32-1:0]    perf_stall_o,
    output logic [31:0]                perf_issue_o
`endif
);

    localparam int idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w_lp = cnt_width(max_outstanding_p);
    localparam logic [cnt_w_lp-1:0]   cnt_max_lp = cnt_w_lp'(max_outstanding_p);
    localparam logic [REG_ID_W:0]     num_req_lp = (REG_ID_W + 1)'(num_req_p);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       issue_en;

    logic [cnt_w_lp-1:0] cnt_q [num_req_p];
    logic [cnt_w_lp-1:0] cnt_d [num_req_p];

    logic [num_req_p-1:0] eligible;
    logic [num_req_p-1:0] grant;
    logic [num_req_p-1:0] inc;
    logic [num_req_p-1:0] dec;
    logic [num_req_p-1:0] ret_hit;
    logic [num_req_p-1:0] ret_live;
    logic [num_req_p-1:0] resp_v;
    logic [num_req_p-1:0] cnt_nz_d;
    logic [idx_w_lp-1:0]  grant_idx;

    logic send;
    logic ret_id_ok;
    logic ret_is_ack;
    logic ret_load_live;
    logic ret_ready_sel;

    logic [addr_width_p-1:0] addr_sel;
    logic [data_width_p-1:0] data_sel;
    logic                    we_sel;
    logic [OP_W-1:0]         op_sel;

    brg_cgra_rr_arbiter #(
        .num_req_p (num_req_p)
    ) u_rr (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .eligible_i  (eligible),
        .yumi_i      (send),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Issue side: credits and per-requester limit gate the single output port
    assign out_v_o            = issue_en & (|eligible) & (out_credits_i != '0);
    assign send               = out_v_o & out_ready_i;
    assign req_if.req_ready_o = inc;

    // Return side: a load reply for a live requester waits for its ready;
    // acks, stale replies and out-of-range tags are consumed immediately
    assign ret_id_ok          = {1'b0, returned_reg_id_r_i} < num_req_lp;
    assign ret_is_ack         = (returned_pkt_type_r_i == RET_PKT_CREDIT);
    assign ret_load_live      = ~ret_is_ack & (|ret_live);
    assign ret_ready_sel      = |(resp_v & req_if.resp_ready_i);
    assign returned_yumi_o    = ~reset_i & returned_v_r_i
                              & (ret_load_live ? ret_ready_sel : 1'b1);
    assign req_if.resp_v_o    = resp_v;
    assign req_if.resp_data_o = returned_data_r_i;

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
        assign eligible[gi] = req_if.req_v_i[gi] & (cnt_q[gi] < cnt_max_lp);
        assign inc[gi]      = send & grant[gi];
        assign ret_hit[gi]  = ret_id_ok & (returned_reg_id_r_i == reg_id_of(gi));
        assign ret_live[gi] = ret_hit[gi] & (cnt_q[gi] != '0);
        assign resp_v[gi]   = ~reset_i & returned_v_r_i & ~ret_is_ack & ret_live[gi];
        assign dec[gi]      = returned_yumi_o & ret_live[gi];
        assign cnt_nz_d[gi] = (cnt_d[gi] != '0);
    end

    // Outstanding counts: decrements only happen from nonzero, increments
    // only below the limit, so the counter can neither wrap nor underflow
    always_comb begin
        for (int k = 0; k < num_req_p; k++) begin
            cnt_d[k] = cnt_q[k] + cnt_w_lp'(inc[k]) - cnt_w_lp'(dec[k]);
        end
    end

    // Outstanding count registers
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < num_req_p; k++) begin
            if (reset_i) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Mux the granted requester's fields into the outgoing packet
    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        we_sel   = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            if (grant[k]) begin
                addr_sel = req_if.req_addr_i[k*addr_width_p +: addr_width_p];
                data_sel = req_if.req_data_i[k*data_width_p +: data_width_p];
                we_sel   = req_if.req_we_i[k];
            end
        end
        op_sel       = we_sel ? OP_STORE : OP_LOAD;
        out_packet_o = {addr_sel,
                        op_sel,
                        we_sel ? STORE_MASK : 4'h0,
                        reg_id_of(int'(grant_idx)),
                        we_sel ? data_sel : {data_width_p{1'b0}},
                        my_y_i, my_x_i, tgt_y_i, tgt_x_i};
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; drain completes once counts settle to zero after this
    // cycle's returns (no issue happens outside RUN)
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (drain_i)    state_d = ST_DRAIN;
            ST_DRAIN:   if (~|cnt_nz_d) state_d = ST_DRAINED;
            ST_DRAINED: if (~drain_i)   state_d = ST_RUN;
            default:                    state_d = ST_RUN;
        endcase
    end

    // FSM outputs, forced quiet while reset is held
    always_comb begin
        issue_en  = ~reset_i & (state_q == ST_RUN);
        drained_o = ~reset_i & (state_q == ST_DRAINED);
    end

`ifdef BRG_CGRA_ARB_PERF_EN
    logic [31:0] stall_q [num_req_p];
    logic [31:0] issue_q;

    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            issue_q <= '0;
            for (int k = 0; k < num_req_p; k++) begin
                stall_q[k] <= '0;
            end
        end else begin
            if (send) begin
                issue_q <= issue_q + 32'd1;
            end
            for (int k = 0; k < num_req_p; k++) begin
                if (req_if.req_v_i[k] & ~inc[k]) begin
                    stall_q[k] <= stall_q[k] + 32'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_perf
        assign perf_stall_o[gi*32 +: 32] = stall_q[gi];
    end
    assign perf_issue_o = issue_q;
`endif

endmodule

// File: tb/tb_brg_cgra_mem_arbiter.sv
// Directed bench for brg_cgra_mem_arbiter with hand-computed expectations.
module tb_brg_cgra_mem_arbiter;

    localparam int NR   = 4;
    localparam int XW   = 4;
    localparam int YW   = 4;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int PKTW = AW + 2 + 4 + 5 + DW + 2 * (XW + YW);  // 91
    // Field offsets (LSB first): dst_x, dst_y, src_x, src_y, payload, reg_id, op_ex, op, addr
    localparam int PAY_LSB  = 16;
    localparam int RID_LSB  = 48;
    localparam int OPEX_LSB = 53;
    localparam int OP_LSB   = 57;
    localparam int ADDR_LSB = 59;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [XW-1:0]   my_x_i, tgt_x_i;
    logic [YW-1:0]   my_y_i, tgt_y_i;
    logic            out_v_o;
    logic [PKTW-1:0] out_packet_o;
    logic            out_ready_i;
    logic [7:0]      out_credits_i;
    logic            returned_v_r_i;
    logic [DW-1:0]   returned_data_r_i;
    logic [4:0]      returned_reg_id_r_i;
    logic [1:0]      returned_pkt_type_r_i;
    logic            returned_yumi_o;
    logic            drain_i;
    logic            drained_o;
`ifdef BRG_CGRA_ARB_PERF_EN
    logic [NR*32-1:0] perf_stall;
    logic [31:0]      perf_issue;
`endif

    brg_cgra_mem_arbiter_if #(.num_req_p(NR), .data_width_p(DW), .addr_width_p(AW)) bus ();

    brg_cgra_mem_arbiter #(
        .num_req_p(NR), .x_cord_width_p(XW), .y_cord_width_p(YW),
        .data_width_p(DW), .addr_width_p(AW),
        .max_out_credits_p(200), .max_outstanding_p(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .my_x_i(my_x_i), .my_y_i(my_y_i), .tgt_x_i(tgt_x_i), .tgt_y_i(tgt_y_i),
        .req_if(bus),
        .out_v_o(out_v_o), .out_packet_o(out_packet_o),
        .out_ready_i(out_ready_i), .out_credits_i(out_credits_i),
        .returned_v_r_i(returned_v_r_i), .returned_data_r_i(returned_data_r_i),
        .returned_reg_id_r_i(returned_reg_id_r_i),
        .returned_pkt_type_r_i(returned_pkt_type_r_i),
        .returned_yumi_o(returned_yumi_o),
        .drain_i(drain_i), .drained_o(drained_o)
`ifdef BRG_CGRA_ARB_PERF_EN
        , .perf_stall_o(perf_stall), .perf_issue_o(perf_issue)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s val=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic look();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        bus.req_v_i           = '0;
        bus.req_we_i          = '0;
        bus.resp_ready_i      = '0;
        returned_v_r_i        = 1'b0;
        returned_data_r_i     = '0;
        returned_reg_id_r_i   = '0;
        returned_pkt_type_r_i = 2'd0;
        drain_i               = 1'b0;
        out_ready_i           = 1'b1;
        out_credits_i         = 8'd200;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic ret_entry(input logic [4:0] id, input logic [1:0] typ, input logic [31:0] d);
        returned_v_r_i        = 1'b1;
        returned_reg_id_r_i   = id;
        returned_pkt_type_r_i = typ;
        returned_data_r_i     = d;
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        my_x_i  = 4'd1;
        my_y_i  = 4'd2;
        tgt_x_i = 4'd3;
        tgt_y_i = 4'd4;
        bus.req_addr_i = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
        bus.req_data_i = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
        reset_i = 1'b0;
        tick();

        // Reset state
        do_reset();
        look();
        check_eq("rst_out_v",   out_v_o, 0);
        check_eq("rst_drained", drained_o, 0);
        check_eq("rst_resp_v",  bus.resp_v_o, 0);
        check_eq("rst_yumi",    returned_yumi_o, 0);
        tick();

        // Round robin over four loaders
        bus.req_v_i = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            look();
            check_eq($sformatf("rr%0d_ready", c), bus.req_ready_o, 4'b0001 << rr_exp[c]);
            check_eq($sformatf("rr%0d_regid", c), out_packet_o[RID_LSB +: 5], rr_exp[c]);
            check_eq($sformatf("rr%0d_addr", c), out_packet_o[ADDR_LSB +: 32], 32'h100 + rr_exp[c]);
            check_eq($sformatf("rr%0d_op", c), out_packet_o[OP_LSB +: 2], 2'd0);
            if (c == 0) check_eq("rr_coords", out_packet_o[15:0], 16'h2143);
            tick();
        end

        // Outstanding limit for requester 2
        do_reset();
        bus.req_v_i = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            look();
            check_eq($sformatf("lim%0d_ready", c), bus.req_ready_o, 4'b0100);
            tick();
        end
        look();
        check_eq("lim_full_ready", bus.req_ready_o, 4'b0000);
        check_eq("lim_full_out_v", out_v_o, 0);
        tick();
        bus.req_v_i = 4'b0101;
        look();
        check_eq("lim_other_ready", bus.req_ready_o, 4'b0001);
        tick();
        ret_entry(5'd2, 2'd1, 32'h1234_5678);
        bus.resp_ready_i = 4'b0100;
        look();
        check_eq("lim_ret_ready", bus.req_ready_o, 4'b0001);
        check_eq("lim_ret_resp_v", bus.resp_v_o, 4'b0100);
        check_eq("lim_ret_yumi", returned_yumi_o, 1);
        tick();
        returned_v_r_i = 1'b0;
        bus.resp_ready_i = 4'b0000;
        look();
        check_eq("lim_reissue_ready", bus.req_ready_o, 4'b0100);
        tick();

        // Credit gating
        do_reset();
        bus.req_v_i   = 4'b1111;
        out_credits_i = 8'd0;
        look();
        check_eq("cred0_out_v", out_v_o, 0);
        check_eq("cred0_ready", bus.req_ready_o, 4'b0000);
        tick();
        out_credits_i = 8'd1;
        look();
        check_eq("cred1_out_v", out_v_o, 1);
        check_eq("cred1_ready", bus.req_ready_o, 4'b0001);
        tick();
        look();
        check_eq("cred1_next_ready", bus.req_ready_o, 4'b0010);
        tick();

        // Load return held until the requester is ready
        do_reset();
        bus.req_v_i = 4'b0010;
        look();
        check_eq("ld_issue_ready", bus.req_ready_o, 4'b0010);
        tick();
        bus.req_v_i = 4'b0000;
        ret_entry(5'd1, 2'd1, 32'hDEAD_BEEF);
        for (int c = 0; c < 3; c++) begin
            look();
            check_eq($sformatf("ld_hold%0d_resp_v", c), bus.resp_v_o, 4'b0010);
            check_eq($sformatf("ld_hold%0d_data", c), bus.resp_data_o, 32'hDEAD_BEEF);
            check_eq($sformatf("ld_hold%0d_yumi", c), returned_yumi_o, 0);
            tick();
        end
        bus.resp_ready_i = 4'b0010;
        look();
        check_eq("ld_take_resp_v", bus.resp_v_o, 4'b0010);
        check_eq("ld_take_yumi", returned_yumi_o, 1);
        tick();
        look();
        check_eq("ld_stale_resp_v", bus.resp_v_o, 4'b0000);
        check_eq("ld_stale_yumi", returned_yumi_o, 1);
        tick();
        returned_v_r_i = 1'b0;
        bus.resp_ready_i = 4'b0000;

        // Drain with two stores outstanding
        do_reset();
        bus.req_v_i  = 4'b0011;
        bus.req_we_i = 4'b0011;
        look();
        check_eq("st0_ready", bus.req_ready_o, 4'b0001);
        check_eq("st0_op", out_packet_o[OP_LSB +: 2], 2'd1);
        check_eq("st0_opex", out_packet_o[OPEX_LSB +: 4], 4'hF);
        check_eq("st0_payload", out_packet_o[PAY_LSB +: 32], 32'hA0A0_A0A0);
        tick();
        look();
        check_eq("st1_ready", bus.req_ready_o, 4'b0010);
        check_eq("st1_payload", out_packet_o[PAY_LSB +: 32], 32'hB1B1_B1B1);
        tick();
        bus.req_v_i = 4'b0000;
        drain_i     = 1'b1;
        look();
        check_eq("dr_enter_drained", drained_o, 0);
        tick();
        bus.req_v_i = 4'b0011;
        look();
        check_eq("dr_noissue_out_v", out_v_o, 0);
        check_eq("dr_noissue_ready", bus.req_ready_o, 4'b0000);
        check_eq("dr_wait_drained", drained_o, 0);
        tick();
        ret_entry(5'd0, 2'd0, 32'h0);
        look();
        check_eq("dr_ack0_yumi", returned_yumi_o, 1);
        check_eq("dr_ack0_drained", drained_o, 0);
        tick();
        ret_entry(5'd1, 2'd0, 32'h0);
        look();
        check_eq("dr_ack1_yumi", returned_yumi_o, 1);
        check_eq("dr_ack1_drained", drained_o, 0);
        tick();
        returned_v_r_i = 1'b0;
        look();
        check_eq("dr_done_drained", drained_o, 1);
        check_eq("dr_done_out_v", out_v_o, 0);
        tick();
        drain_i = 1'b0;
        look();
        check_eq("dr_release_drained", drained_o, 1);
        tick();
        look();
        check_eq("dr_run_drained", drained_o, 0);
        check_eq("dr_run_ready", bus.req_ready_o, 4'b0001);
        tick();

        // Reset mid-transaction, then a stale return
        do_reset();
        bus.req_v_i = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            look();
            check_eq($sformatf("mr_issue%0d_ready", c), bus.req_ready_o, 4'b0001);
            tick();
        end
        reset_i = 1'b1;
        ret_entry(5'd0, 2'd1, 32'h5555_AAAA);
        bus.resp_ready_i = 4'b0001;
        look();
        check_eq("mr_inrst_out_v", out_v_o, 0);
        check_eq("mr_inrst_ready", bus.req_ready_o, 4'b0000);
        check_eq("mr_inrst_resp_v", bus.resp_v_o, 4'b0000);
        check_eq("mr_inrst_yumi", returned_yumi_o, 0);
        tick();
        reset_i = 1'b0;
        bus.req_v_i = 4'b0000;
        look();
        check_eq("mr_stale_resp_v", bus.resp_v_o, 4'b0000);
        check_eq("mr_stale_yumi", returned_yumi_o, 1);
        tick();
        returned_v_r_i = 1'b0;
        bus.resp_ready_i = 4'b0000;
        bus.req_v_i = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            look();
            check_eq($sformatf("mr_refill%0d_ready", c), bus.req_ready_o, 4'b0001);
            tick();
        end
        look();
        check_eq("mr_full_ready", bus.req_ready_o, 4'b0000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brg_cgra_mem_arbiter.md
Name: brg_cgra_mem_arbiter

Overview:
Shares the tile's single endpoint master port among the CGRA's memory engines (num_req_p requesters, 4 for the 2x2 array). It issues remote loads and stores with round-robin priority and gates them on endpoint credits. It tags each packet with the requester index and routes returned load data back to the requester that issued it. It sits between the CGRA datapath memory engines and bsg_manycore_endpoint_standard out_*/returned_* ports, and supports a drain handshake used by the accelerator controller before reconfiguration.

Parameters:
num_req_p, 4, number of memory-engine requesters (1..32)
x_cord_width_p, "inv", mesh x coordinate width
y_cord_width_p, "inv", mesh y coordinate width
data_width_p, 32, data width
addr_width_p, 32, packet word-address width
max_out_credits_p, 200, endpoint credit counter range
max_outstanding_p, 4, per-requester outstanding request limit

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
my_x_i / my_y_i  in  x/y_cord_width_p  own coordinates (packet src)
tgt_x_i / tgt_y_i  in  x/y_cord_width_p  destination tile for all requests
req_v_i  in  num_req_p  request valid per requester
req_we_i  in  num_req_p  1=store, 0=load
req_addr_i  in  num_req_p*addr_width_p  word address, requester i at slice i
req_data_i  in  num_req_p*data_width_p  store data
req_ready_o  out  num_req_p  request accepted this cycle
resp_v_o  out  num_req_p  load response valid
resp_data_o  out  data_width_p  load data (shared bus)
resp_ready_i  in  num_req_p  requester accepts response
out_v_o  out  1  to endpoint out_v_i
out_packet_o  out  packet width  bsg_manycore_packet_s
out_ready_i  in  1  endpoint out_ready_o
out_credits_i  in  $clog2(max_out_credits_p+1)  endpoint credits
returned_v_r_i / returned_data_r_i / returned_reg_id_r_i (5) / returned_pkt_type_r_i  in  endpoint returned fields
returned_yumi_o  out  1  consume returned entry
drain_i  in  1  stop issuing and wait for completion
drained_o  out  1  no outstanding requests, issue stopped

Behaviour:
- Eligible[i] = req_v_i[i] & (outstanding[i] < max_outstanding_p). Grant is combinational round-robin over eligible requesters, starting at rr_ptr.
- out_v_o = state==RUN & |eligible & (out_credits_i != 0). req_ready_o[i] = grant[i] & out_v_o & out_ready_i. Zero-cycle latency: a request is accepted in the cycle it is sent.
- Packet fields: op = store when we else load; addr = req_addr_i slice; payload = req_data_i slice (0 for loads); reg_id = requester index; src = my_x/y; dst = tgt_x/y.
- On a send, rr_ptr <= granted+1 mod num_req_p and outstanding[granted] increments.
- Returned entry, with i = reg_id:
  - Write ack: returned_yumi_o=1 the same cycle; outstanding[i] decrements.
  - Load: resp_v_o[i]=1 and resp_data_o=data; returned_yumi_o = resp_ready_i[i]; outstanding[i] decrements on yumi. The entry is held otherwise.
- Ordering: the network delivers in order for a single src/dst pair.
- Counter arithmetic: a send and a return for the same i in one cycle leave the count unchanged. The counter never wraps; issue blocks at max.
- FSM states RUN, DRAIN, DRAINED:
  - RUN->DRAIN on drain_i.
  - DRAIN->DRAINED when all outstanding==0. This can happen in the same cycle as entry if already zero, giving DRAINED next cycle.
  - DRAINED->RUN when drain_i falls.
  - No issue in DRAIN or DRAINED. Returns are still processed in every state.
- drained_o = state==DRAINED.
- Reset values: state=RUN, rr_ptr=0, outstanding=0. Reset is valid mid-transaction; responses arriving after reset for the cleared counters are consumed and dropped, and counters saturate at 0.
- Reset outputs: out_v_o=0, req_ready_o=0, resp_v_o=0, returned_yumi_o=0 (gated by returned_v_r_i), drained_o=0.
- reg_id values >= num_req_p are consumed and dropped.

Optional Feature:
BRG_CGRA_ARB_PERF_EN
- Defined: per-requester 32-bit stall counters, incremented each cycle req_v_i[i]&~req_ready_o[i], plus a 32-bit total-issue counter. Exposed on output perf_stall_o (num_req_p*32) and perf_issue_o (32). Cleared by reset; wrap at 2^32.
- Undefined: the counters and ports are absent.

Decomposition:
- Shared package brg_cgra_pkg holds:
  - FSM state enum
  - requester-index-to-reg_id encoding constant
  - outstanding-count width localparam helper
- One sub-module, brg_cgra_rr_arbiter: eligible vector + rr_ptr in, one-hot grant + index out, pointer update on a yumi input.

Test Plan:
- Reqs 0..3 all valid loads, credits=200, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; reg_id matches index.
- Requester 2 issues 4 loads with no returns (max_outstanding_p=4) -> 5th load is not ready while others still issue; after one return, req 2 is granted next.
- out_credits_i=0 with req_v_i=4'b1111 -> out_v_o=0 and all req_ready_o=0; credits=1 -> one send, to rr_ptr.
- Load return reg_id=1, data=0xDEADBEEF, resp_ready_i[1]=0 for 3 cycles -> resp_v_o[1] high with data held and returned_yumi_o=0; yumi in the cycle ready rises.
- 2 stores outstanding, assert drain_i -> no new issue; drained_o rises 1 cycle after the second write ack; deassert drain_i -> RUN next cycle.
- Reset asserted with outstanding loads, then stale return reg_id=0 -> consumed, counter stays 0, resp_v_o stays 0.
